operand_select_stage: RTL and testbench
=======================================

Name: operand_select_stage

Overview:
- Registered successor to the combinational operand mux: selects ALU and next-PC operands, adds register-operand forwarding from NUM_FWD writeback/bypass sources, and holds one instruction in an output pipeline register with a valid/ready handshake.
- Sits between decode/register-read and execute.
- Stalls intake when a needed source register has a result in flight whose data is not yet available (load-use hazard).

Parameters:
- XLEN, 32, datapath width of all operand/data buses
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest and has the highest priority
- REG_ADDR_W, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill the held instruction and any presented instruction this cycle
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts the instruction this cycle
- opcode  in  7  RV32I major opcode
- op1_type  in  2  ALU op1 source select
- op2_type  in  2  ALU op2 source select
- rs1_addr  in  REG_ADDR_W  source register 1 index
- rs2_addr  in  REG_ADDR_W  source register 2 index
- rs1_data  in  XLEN  register-file read data 1
- rs2_data  in  XLEN  register-file read data 2
- imm  in  XLEN  sign-extended immediate
- pc  in  XLEN  instruction PC
- fwd_valid  in  NUM_FWD  source i holds a result for fwd_rd[i]
- fwd_pending  in  NUM_FWD  source i will write fwd_rd[i], but its data is not yet available
- fwd_rd  in  NUM_FWD*REG_ADDR_W  destination index per source, packed with source i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- fwd_data  in  NUM_FWD*XLEN  result data per source, packed in the same way
- out_valid  out  1  registered operands valid
- out_ready  in  1  downstream accepts
- alu_op1  out  XLEN  registered ALU operand 1
- alu_op2  out  XLEN  registered ALU operand 2
- npc_op1  out  XLEN  registered next-PC base
- npc_op2  out  XLEN  registered next-PC offset
- stall_cnt  out  16  saturating count of cycles in which a hazard blocked intake

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst. On reset, out_valid=0, all four operand outputs=0, stall_cnt=0.
- Operand type encodings: NONE=0, REG=1, IMM=2, PC=3.
  - alu_op1: 0 / fwd(rs1) / imm / pc.
  - alu_op2: 0 / fwd(rs2) / imm / pc.
- npc_op1: fwd(rs1) for JALR; pc for every other opcode, including unknown opcodes.
- npc_op2: imm for JAL, JALR and BRANCH; otherwise the constant 4, zero-extended to XLEN.
- fwd(r) selection:
  - r==0 always yields 0; x0 is never forwarded or hazarded.
  - Otherwise, the lowest index i with (fwd_valid[i] | fwd_pending[i]) and fwd_rd[i]==r wins.
  - If the winner has fwd_pending set, a hazard is raised; if it has only fwd_valid set, fwd_data[i] is used.
  - With no winner, the register-file data is used.
- need1 = (op1_type==REG) | (opcode==JALR). need2 = (op2_type==REG). A hazard counts only for a needed operand.
- hazard = in_valid & ((need1 & pend(rs1)) | (need2 & pend(rs2))).
- Handshake:
  - in_ready = (~out_valid | out_ready) & ~hazard.
  - Accept = in_valid & in_ready. Accept loads all four operands and sets out_valid=1 in the same edge.
  - Latency: 1 cycle from accept to out_valid.
- Output behaviour:
  - out_valid & ~out_ready holds all outputs stable.
  - out_valid & out_ready & ~accept clears out_valid; the operand outputs keep their last values.
  - Simultaneous drain and accept is full throughput: out_valid stays 1 with the new data.
- Flush has the highest priority after rst. On flush the next edge clears out_valid, no accept happens that cycle, and in_ready is forced to 0.
- stall_cnt increments on each cycle with hazard & ~flush and saturates at 16'hFFFF.
- in_valid=0 has no effect on stall_cnt. The forwarding and hazard logic is combinational in the same cycle.

Decomposition:
- Shared package/header:
  - RV32I opcode constants: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP.
  - OP_TYPE_NONE, OP_TYPE_REG, OP_TYPE_IMM, OP_TYPE_PC.
  - Constant NPC_STEP=4.
- Sub-module fwd_select, instantiated twice, once per source register.
  - Parameters: XLEN, NUM_FWD, REG_ADDR_W.
  - Purely combinational priority match.
  - Outputs: selected data and a pending flag.

Test Plan:
- Reset then idle: assert rst 2 cycles -> out_valid=0, all operands 0, stall_cnt=0, in_ready=1.
- OP with op1=REG, op2=IMM, rs1=3, rs1_data=0x10, imm=0xFFFFFFF0, pc=0x100 -> next cycle alu_op1=0x10, alu_op2=0xFFFFFFF0, npc_op1=0x100, npc_op2=4.
- Forward priority: rs1=5, fwd_valid=2'b11, fwd_rd={5,5}, fwd_data={0xBBBB,0xAAAA} -> alu_op1=0xAAAA. Repeat with rs1=0 -> alu_op1=0.
- Load-use: JALR rs1=7, fwd_pending[0]=1 with fwd_rd[0]=7 for 3 cycles, then fwd_valid[0]=1 with data 0x2000 and imm=8 -> in_ready=0 for 3 cycles, stall_cnt=3, then npc_op1=0x2000, npc_op2=8.
- Backpressure: out_ready=0 with a second instruction presented -> outputs hold, in_ready=0. Raise out_ready -> back-to-back transfer with no bubble.
- Flush mid-hold: out_valid=1, out_ready=0, pulse flush with in_valid=1 -> next cycle out_valid=0 and the presented instruction is not captured.

Source files
------------

// File: rtl/operand_select_stage_pkg.sv
// Shared opcode, operand-type and next-PC constants for the operand select stage.
package operand_select_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    OP_TYPE_NONE = 2'd0,
    OP_TYPE_REG  = 2'd1,
    OP_TYPE_IMM  = 2'd2,
    OP_TYPE_PC   = 2'd3
  } op_type_e;

  localparam int NPC_STEP = 4;

  // JALR reads rs1 as its jump base even when the ALU does not use it.
  function automatic logic rs1_needed(input logic [6:0] opc, input logic [1:0] op1_type);
    return (op_type_e'(op1_type) == OP_TYPE_REG) || (opc == OPC_JALR);
  endfunction

  function automatic logic rs2_needed(input logic [1:0] op2_type);
    return op_type_e'(op2_type) == OP_TYPE_REG;
  endfunction

  function automatic logic npc_uses_imm(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/operand_select_stage_if.sv
// Upstream instruction, forwarding, downstream operand and stall-count signals of the stage.
interface operand_select_stage_if #(
  parameter int XLEN       = 32,
  parameter int NUM_FWD    = 2,
  parameter int REG_ADDR_W = 5
) ();

  logic                          in_valid;
  logic                          in_ready;
  logic [6:0]                    opcode;
  logic [1:0]                    op1_type;
  logic [1:0]                    op2_type;
  logic [REG_ADDR_W-1:0]         rs1_addr;
  logic [REG_ADDR_W-1:0]         rs2_addr;
  logic [XLEN-1:0]               rs1_data;
  logic [XLEN-1:0]               rs2_data;
  logic [XLEN-1:0]               imm;
  logic [XLEN-1:0]               pc;

  logic [NUM_FWD-1:0]            fwd_valid;
  logic [NUM_FWD-1:0]            fwd_pending;
  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd;
  logic [NUM_FWD*XLEN-1:0]       fwd_data;

  logic                          out_valid;
  logic                          out_ready;
  logic [XLEN-1:0]               alu_op1;
  logic [XLEN-1:0]               alu_op2;
  logic [XLEN-1:0]               npc_op1;
  logic [XLEN-1:0]               npc_op2;
  logic [15:0]                   stall_cnt;

  modport slave (
    input  in_valid, opcode, op1_type, op2_type, rs1_addr, rs2_addr,
           rs1_data, rs2_data, imm, pc,
           fwd_valid, fwd_pending, fwd_rd, fwd_data, out_ready,
    output in_ready, out_valid, alu_op1, alu_op2, npc_op1, npc_op2, stall_cnt
  );

  modport master (
    output in_valid, opcode, op1_type, op2_type, rs1_addr, rs2_addr,
           rs1_data, rs2_data, imm, pc,
           fwd_valid, fwd_pending, fwd_rd, fwd_data, out_ready,
    input  in_ready, out_valid, alu_op1, alu_op2, npc_op1, npc_op2, stall_cnt
  );

endinterface

// File: rtl/operand_select_stage_fwd_select.sv
// Combinational priority forwarding match for one source register; lowest source index wins.
// Reports pending when the winning source has not produced its data yet; x0 never matches.
module operand_select_stage_fwd_select #(
  parameter int XLEN       = 32,
  parameter int NUM_FWD    = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0]         addr_i,
  input  logic [XLEN-1:0]               rf_data_i,
  input  logic [NUM_FWD-1:0]            fwd_valid_i,
  input  logic [NUM_FWD-1:0]            fwd_pending_i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd_i,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data_i,
  output logic [XLEN-1:0]               data_o,
  output logic                          pending_o
);

  always_comb begin
    data_o    = rf_data_i;
    pending_o = 1'b0;
    // Walk oldest to youngest so the youngest match overwrites last.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if ((fwd_valid_i[i] || fwd_pending_i[i]) &&
          (fwd_rd_i[i*REG_ADDR_W +: REG_ADDR_W] == addr_i)) begin
        pending_o = fwd_pending_i[i];
        data_o    = fwd_pending_i[i] ? rf_data_i : fwd_data_i[i*XLEN +: XLEN];
      end
    end
    if (addr_i == '0) begin
      data_o    = '0;
      pending_o = 1'b0;
    end
  end

endmodule

// File: rtl/operand_select_stage.sv
// Registered ALU/next-PC operand select with forwarding; 1-cycle accept-to-valid latency.
// Full-throughput valid/ready output register; intake stalls on load-use hazards and flush.
module operand_select_stage
  import operand_select_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_FWD    = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  operand_select_stage_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic [XLEN-1:0] npc_op1;
    logic [XLEN-1:0] npc_op2;
  } ops_t;

  logic [XLEN-1:0] rs1_fwd_dat;
  logic [XLEN-1:0] rs2_fwd_dat;
  logic            rs1_pend;
  logic            rs2_pend;
  logic            hazard;
  logic            in_rdy;
  logic            accept;
  ops_t            ops_new;

  ops_t            ops_q,       ops_d;
  logic            out_vld_q,   out_vld_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  operand_select_stage_fwd_select #(
    .XLEN       (XLEN),
    .NUM_FWD    (NUM_FWD),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs1 (
    .addr_i        (bus.rs1_addr),
    .rf_data_i     (bus.rs1_data),
    .fwd_valid_i   (bus.fwd_valid),
    .fwd_pending_i (bus.fwd_pending),
    .fwd_rd_i      (bus.fwd_rd),
    .fwd_data_i    (bus.fwd_data),
    .data_o        (rs1_fwd_dat),
    .pending_o     (rs1_pend)
  );

  operand_select_stage_fwd_select #(
    .XLEN       (XLEN),
    .NUM_FWD    (NUM_FWD),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs2 (
    .addr_i        (bus.rs2_addr),
    .rf_data_i     (bus.rs2_data),
    .fwd_valid_i   (bus.fwd_valid),
    .fwd_pending_i (bus.fwd_pending),
    .fwd_rd_i      (bus.fwd_rd),
    .fwd_data_i    (bus.fwd_data),
    .data_o        (rs2_fwd_dat),
    .pending_o     (rs2_pend)
  );

  assign hazard = bus.in_valid &&
                  ((rs1_needed(bus.opcode, bus.op1_type) && rs1_pend) ||
                   (rs2_needed(bus.op2_type) && rs2_pend));
  assign in_rdy = (!out_vld_q || bus.out_ready) && !hazard && !flush;
  assign accept = bus.in_valid && in_rdy;

  always_comb begin
    ops_new = '0;
    case (op_type_e'(bus.op1_type))
      OP_TYPE_REG: ops_new.alu_op1 = rs1_fwd_dat;
      OP_TYPE_IMM: ops_new.alu_op1 = bus.imm;
      OP_TYPE_PC:  ops_new.alu_op1 = bus.pc;
      default:     ops_new.alu_op1 = '0;
    endcase
    case (op_type_e'(bus.op2_type))
      OP_TYPE_REG: ops_new.alu_op2 = rs2_fwd_dat;
      OP_TYPE_IMM: ops_new.alu_op2 = bus.imm;
      OP_TYPE_PC:  ops_new.alu_op2 = bus.pc;
      default:     ops_new.alu_op2 = '0;
    endcase
    ops_new.npc_op1 = (bus.opcode == OPC_JALR) ? rs1_fwd_dat : bus.pc;
    ops_new.npc_op2 = npc_uses_imm(bus.opcode) ? bus.imm : XLEN'(NPC_STEP);
  end

  always_comb begin
    ops_d       = ops_q;
    out_vld_d   = out_vld_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      out_vld_d = 1'b0;
    end else if (accept) begin
      out_vld_d = 1'b1;
      ops_d     = ops_new;
    end else if (bus.out_ready) begin
      out_vld_d = 1'b0;
    end
    if (hazard && !flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q       <= '0;
      out_vld_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ops_q       <= ops_d;
      out_vld_q   <= out_vld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld_q;
  assign bus.alu_op1   = ops_q.alu_op1;
  assign bus.alu_op2   = ops_q.alu_op2;
  assign bus.npc_op1   = ops_q.npc_op1;
  assign bus.npc_op2   = ops_q.npc_op2;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_select_stage.sv
// Directed and randomized checks of operand_select_stage against a behavioural operand model.
module tb_operand_select_stage;
  import operand_select_stage_pkg::*;

  localparam int XLEN       = 32;
  localparam int NUM_FWD    = 2;
  localparam int REG_ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  operand_select_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_ADDR_W(REG_ADDR_W)) bus ();

  operand_select_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic                  fv   [NUM_FWD];
  logic                  fp   [NUM_FWD];
  logic [REG_ADDR_W-1:0] frd  [NUM_FWD];
  logic [XLEN-1:0]       fdat [NUM_FWD];

  // Model state: what the output register should hold.
  logic        m_valid;
  logic [31:0] m_ops [4];
  logic [15:0] m_cnt;

  logic [6:0] opc_tab [10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_fwd();
    for (int i = 0; i < NUM_FWD; i++) begin
      bus.fwd_valid[i]                           = fv[i];
      bus.fwd_pending[i]                         = fp[i];
      bus.fwd_rd[i*REG_ADDR_W +: REG_ADDR_W]     = frd[i];
      bus.fwd_data[i*XLEN +: XLEN]               = fdat[i];
    end
  endtask

  task automatic clear_fwd();
    for (int i = 0; i < NUM_FWD; i++) begin
      fv[i] = 1'b0; fp[i] = 1'b0; frd[i] = '0; fdat[i] = '0;
    end
    drive_fwd();
  endtask

  // Youngest matching in-flight result supplies the register value.
  function automatic void ref_fwd(input logic [4:0] r, input logic [31:0] rf,
                                  output logic [31:0] d, output logic p);
    int win;
    win = -1;
    d = rf;
    p = 1'b0;
    if (r == 5'd0) begin
      d = 32'd0;
      return;
    end
    for (int i = 0; i < NUM_FWD; i++)
      if (win < 0 && (fv[i] || fp[i]) && frd[i] == r) win = i;
    if (win >= 0) begin
      p = fp[win];
      if (!fp[win]) d = fdat[win];
    end
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] t, input logic [31:0] r);
    case (t)
      2'd1:    return r;
      2'd2:    return bus.imm;
      2'd3:    return bus.pc;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: check in_ready against the model, advance, then check all outputs.
  task automatic step(input string tag);
    logic [31:0] d1, d2, nops [4];
    logic p1, p2, need1, need2, haz, rdy, acc;
    #1;
    ref_fwd(bus.rs1_addr, bus.rs1_data, d1, p1);
    ref_fwd(bus.rs2_addr, bus.rs2_data, d2, p2);
    need1 = (bus.op1_type == 2'd1) || (bus.opcode == 7'b1100111);
    need2 = (bus.op2_type == 2'd1);
    haz   = bus.in_valid && ((need1 && p1) || (need2 && p2));
    rdy   = (!m_valid || bus.out_ready) && !haz && !flush;
    acc   = bus.in_valid && rdy;
    chk({tag, "/in_ready"}, {31'd0, bus.in_ready}, {31'd0, rdy});
    nops[0] = pick(bus.op1_type, d1);
    nops[1] = pick(bus.op2_type, d2);
    nops[2] = (bus.opcode == 7'b1100111) ? d1 : bus.pc;
    nops[3] = (bus.opcode == 7'b1101111 || bus.opcode == 7'b1100111 ||
               bus.opcode == 7'b1100011) ? bus.imm : 32'd4;
    @(posedge clk);
    #1;
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      for (int k = 0; k < 4; k++) m_ops[k] = nops[k];
    end else if (bus.out_ready) m_valid = 1'b0;
    if (haz && !flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    chk({tag, "/out_valid"}, {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk({tag, "/alu_op1"},   bus.alu_op1, m_ops[0]);
    chk({tag, "/alu_op2"},   bus.alu_op2, m_ops[1]);
    chk({tag, "/npc_op1"},   bus.npc_op1, m_ops[2]);
    chk({tag, "/npc_op2"},   bus.npc_op2, m_ops[3]);
    chk({tag, "/stall_cnt"}, {16'd0, bus.stall_cnt}, {16'd0, m_cnt});
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [1:0] t1, input logic [1:0] t2,
                           input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] im, input logic [31:0] pcv);
    bus.opcode = opc;  bus.op1_type = t1; bus.op2_type = t2;
    bus.rs1_addr = r1; bus.rs2_addr = r2;
    bus.rs1_data = d1; bus.rs2_data = d2;
    bus.imm = im;      bus.pc = pcv;
  endtask

  initial begin
    opc_tab = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, 7'h7F};
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_instr(OPC_OP, 2'd0, 2'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    clear_fwd();

    // Reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_valid = 1'b0; m_cnt = 16'd0;
    for (int k = 0; k < 4; k++) m_ops[k] = 32'd0;
    #1;
    chk("reset/out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset/alu_op1",   bus.alu_op1, 32'd0);
    chk("reset/alu_op2",   bus.alu_op2, 32'd0);
    chk("reset/npc_op1",   bus.npc_op1, 32'd0);
    chk("reset/npc_op2",   bus.npc_op2, 32'd0);
    chk("reset/stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    chk("reset/in_ready",  {31'd0, bus.in_ready}, 32'd1);

    // Plain OP: rs1 register, immediate op2
    bus.in_valid = 1'b1;
    set_instr(OPC_OP, 2'd1, 2'd2, 5'd3, 5'd0, 32'h10, 32'd0, 32'hFFFF_FFF0, 32'h100);
    step("op");
    chk("op/alu_op1_const", bus.alu_op1, 32'h10);
    chk("op/alu_op2_const", bus.alu_op2, 32'hFFFF_FFF0);
    chk("op/npc_op1_const", bus.npc_op1, 32'h100);
    chk("op/npc_op2_const", bus.npc_op2, 32'd4);

    // Forward priority, then x0
    fv[0] = 1'b1; fv[1] = 1'b1; frd[0] = 5'd5; frd[1] = 5'd5;
    fdat[0] = 32'hAAAA; fdat[1] = 32'hBBBB;
    drive_fwd();
    set_instr(OPC_OP, 2'd1, 2'd2, 5'd5, 5'd0, 32'h1234, 32'd0, 32'd1, 32'h104);
    step("fwd_prio");
    chk("fwd_prio/alu_op1_const", bus.alu_op1, 32'hAAAA);
    bus.rs1_addr = 5'd0;
    step("fwd_x0");
    chk("fwd_x0/alu_op1_const", bus.alu_op1, 32'd0);

    // Load-use on JALR base
    clear_fwd();
    fp[0] = 1'b1; frd[0] = 5'd7;
    drive_fwd();
    set_instr(OPC_JALR, 2'd3, 2'd2, 5'd7, 5'd0, 32'h55, 32'd0, 32'd8, 32'h200);
    for (int c = 0; c < 3; c++) step("loaduse_stall");
    chk("loaduse/stall_cnt_const", {16'd0, bus.stall_cnt}, 32'd3);
    fp[0] = 1'b0; fv[0] = 1'b1; fdat[0] = 32'h2000;
    drive_fwd();
    step("loaduse_go");
    chk("loaduse/npc_op1_const", bus.npc_op1, 32'h2000);
    chk("loaduse/npc_op2_const", bus.npc_op2, 32'd8);

    // Backpressure then back-to-back
    clear_fwd();
    set_instr(OPC_OPIMM, 2'd2, 2'd3, 5'd1, 5'd2, 32'd0, 32'd0, 32'h11, 32'h300);
    step("bp_a");
    bus.out_ready = 1'b0;
    set_instr(OPC_OPIMM, 2'd2, 2'd3, 5'd1, 5'd2, 32'd0, 32'd0, 32'h22, 32'h304);
    step("bp_hold");
    chk("bp_hold/alu_op1_const", bus.alu_op1, 32'h11);
    bus.out_ready = 1'b1;
    step("bp_b");
    chk("bp_b/alu_op1_const", bus.alu_op1, 32'h22);
    set_instr(OPC_OPIMM, 2'd2, 2'd3, 5'd1, 5'd2, 32'd0, 32'd0, 32'h33, 32'h308);
    step("bp_c");
    chk("bp_c/out_valid_const", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_c/alu_op1_const", bus.alu_op1, 32'h33);

    // Flush while holding
    bus.out_ready = 1'b0;
    set_instr(OPC_OPIMM, 2'd2, 2'd3, 5'd1, 5'd2, 32'd0, 32'd0, 32'h44, 32'h30C);
    step("fl_hold");
    flush = 1'b1;
    step("flush");
    chk("flush/out_valid_const", {31'd0, bus.out_valid}, 32'd0);
    chk("flush/alu_op1_const", bus.alu_op1, 32'h33);
    flush = 1'b0;
    bus.out_ready = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NUM_FWD; i++) begin
        fv[i]   = 1'($urandom_range(0, 1));
        fp[i]   = ($urandom_range(0, 3) == 0);
        frd[i]  = 5'($urandom_range(0, 7));
        fdat[i] = $urandom;
      end
      drive_fwd();
      set_instr(opc_tab[$urandom_range(0, 9)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom, $urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
